id_ex_stage: RTL and testbench

ID/EX pipeline register with integrated load-use hazard detection for the 16-bit, 16-register five-stage pipeline. Captures decoded operands and control from ID each cycle and presents them to EX and to the forwarding logic (IDEX_rs, IDEX_rt, IDEX_rd, control bits). Decides when a load-use stall is required, inserts the bubble, and holds PC and IF/ID. Also keeps a saturating count of load-use stall cycles for performance readout.

---
 rtl/wisc_pkg.sv | 33 +++
 rtl/id_ex_stage_if.sv | 40 ++++
 rtl/hazard_detect.sv | 26 ++
 rtl/id_ex_stage.sv | 116 +++++++++++
 tb/tb_id_ex_stage.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/wisc_pkg.sv
// Shared widths, ALU-op encodings and the bubble control word for the
// 16-bit, 16-register five-stage pipeline.
package wisc_pkg;

  localparam int WISC_DW = 16;
  localparam int WISC_RW = 4;
  localparam int WISC_AW = 4;

  typedef enum logic [WISC_AW-1:0] {
    ALU_ADD  = 4'h0,
    ALU_SUB  = 4'h1,
    ALU_AND  = 4'h2,
    ALU_OR   = 4'h3,
    ALU_XOR  = 4'h4,
    ALU_SLL  = 4'h5,
    ALU_SRL  = 4'h6,
    ALU_PASS = 4'h7
  } alu_op_e;

  // Single-bit control flags carried from ID into EX.
  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
    logic alu_src;
    logic halt;
  } ctrl_t;

  // A bubble must not write anything, touch memory or halt.
  localparam ctrl_t CTRL_BUBBLE = '{default: 1'b0};

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode-side inputs and EX-side registered outputs of the ID/EX register.
// master drives the decode fields, slave is the pipeline register itself.
interface id_ex_stage_if #(
  parameter int DW = 16,
  parameter int RW = 4,
  parameter int AW = 4
);
  logic [RW-1:0] id_rs, id_rt, id_rd;
  logic          id_uses_rs, id_uses_rt, id_is_store;
  logic [DW-1:0] id_data1, id_data2, id_imm, id_pc2;
  logic          id_reg_write, id_mem_read, id_mem_write;
  logic          id_mem_to_reg, id_alu_src, id_halt;
  logic [AW-1:0] id_alu_op;

  logic [RW-1:0] ex_rs, ex_rt, ex_rd;
  logic [DW-1:0] ex_data1, ex_data2, ex_imm, ex_pc2;
  logic          ex_reg_write, ex_mem_read, ex_mem_write;
  logic          ex_mem_to_reg, ex_alu_src, ex_halt;
  logic [AW-1:0] ex_alu_op;

  modport master (
    output id_rs, id_rt, id_rd, id_uses_rs, id_uses_rt, id_is_store,
           id_data1, id_data2, id_imm, id_pc2,
           id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg,
           id_alu_src, id_halt, id_alu_op,
    input  ex_rs, ex_rt, ex_rd, ex_data1, ex_data2, ex_imm, ex_pc2,
           ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg,
           ex_alu_src, ex_halt, ex_alu_op
  );

  modport slave (
    input  id_rs, id_rt, id_rd, id_uses_rs, id_uses_rt, id_is_store,
           id_data1, id_data2, id_imm, id_pc2,
           id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg,
           id_alu_src, id_halt, id_alu_op,
    output ex_rs, ex_rt, ex_rd, ex_data1, ex_data2, ex_imm, ex_pc2,
           ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg,
           ex_alu_src, ex_halt, ex_alu_op
  );
endinterface

// File: rtl/hazard_detect.sv
// Load-use hazard detection: a load in EX whose destination is read by the
// instruction in ID. Store data (rt) of a store is covered by MEM-to-MEM
// forwarding, so only the address base (rs) stalls a store.
module hazard_detect #(
  parameter int RW = 4
) (
  input  logic          ex_mem_read,
  input  logic [RW-1:0] ex_rd,
  input  logic          id_flush,
  input  logic          id_uses_rs,
  input  logic [RW-1:0] id_rs,
  input  logic          id_uses_rt,
  input  logic [RW-1:0] id_rt,
  input  logic          id_is_store,
  output logic          hz
);
  logic rs_dep, rt_dep;

  // Register 0 is hard-wired, so it never sources a hazard; a flushed
  // instruction is discarded anyway and must not hold the front end.
  always_comb begin
    rs_dep = id_uses_rs && (ex_rd == id_rs);
    rt_dep = id_uses_rt && (ex_rd == id_rt) && !id_is_store;
    hz     = ex_mem_read && (ex_rd != '0) && !id_flush && (rs_dep || rt_dep);
  end
endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, front-end hold
// outputs and a saturating load-use stall counter.
module id_ex_stage
  import wisc_pkg::*;
#(
  parameter int DW = WISC_DW,
  parameter int RW = WISC_RW,
  parameter int AW = WISC_AW,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          mem_stall,
  input  logic          id_flush,
  id_ex_stage_if.slave  bus,
  output logic          pc_hold,
  output logic          ifid_hold,
  output logic [CW-1:0] lu_stall_cnt
);

  logic          hz;
  ctrl_t         ctrl_q;
  ctrl_t         id_ctrl;
  logic [RW-1:0] rs_q, rt_q, rd_q;
  logic [DW-1:0] data1_q, data2_q, imm_q, pc2_q;
  logic [AW-1:0] alu_op_q;

  hazard_detect #(.RW(RW)) u_hazard_detect (
    .ex_mem_read (ctrl_q.mem_read),
    .ex_rd       (rd_q),
    .id_flush    (id_flush),
    .id_uses_rs  (bus.id_uses_rs),
    .id_rs       (bus.id_rs),
    .id_uses_rt  (bus.id_uses_rt),
    .id_rt       (bus.id_rt),
    .id_is_store (bus.id_is_store),
    .hz          (hz)
  );

  // Collect decode control flags into one word so a bubble is one assignment.
  always_comb begin
    id_ctrl            = CTRL_BUBBLE;
    id_ctrl.reg_write  = bus.id_reg_write;
    id_ctrl.mem_read   = bus.id_mem_read;
    id_ctrl.mem_write  = bus.id_mem_write;
    id_ctrl.mem_to_reg = bus.id_mem_to_reg;
    id_ctrl.alu_src    = bus.id_alu_src;
    id_ctrl.halt       = bus.id_halt;
  end

  assign pc_hold   = hz || mem_stall;
  assign ifid_hold = hz || mem_stall;

  // Pipeline register: memory freeze wins, then bubble, then normal capture.
  // Bubble indices are zero so forwarding never matches a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q   <= CTRL_BUBBLE;
      alu_op_q <= '0;
      rs_q     <= '0;
      rt_q     <= '0;
      rd_q     <= '0;
      data1_q  <= '0;
      data2_q  <= '0;
      imm_q    <= '0;
      pc2_q    <= '0;
    end else if (mem_stall) begin
      ctrl_q   <= ctrl_q;
    end else if (hz || id_flush) begin
      ctrl_q   <= CTRL_BUBBLE;
      alu_op_q <= '0;
      rs_q     <= '0;
      rt_q     <= '0;
      rd_q     <= '0;
      data1_q  <= '0;
      data2_q  <= '0;
      imm_q    <= '0;
      pc2_q    <= '0;
    end else begin
      ctrl_q   <= id_ctrl;
      alu_op_q <= bus.id_alu_op;
      rs_q     <= bus.id_rs;
      rt_q     <= bus.id_rt;
      rd_q     <= bus.id_rd;
      data1_q  <= bus.id_data1;
      data2_q  <= bus.id_data2;
      imm_q    <= bus.id_imm;
      pc2_q    <= bus.id_pc2;
    end
  end

  // Count cycles actually lost to load-use bubbles; stick at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lu_stall_cnt <= '0;
    end else if (hz && !mem_stall && (lu_stall_cnt != {CW{1'b1}})) begin
      lu_stall_cnt <= lu_stall_cnt + 1'b1;
    end
  end

  assign bus.ex_rs         = rs_q;
  assign bus.ex_rt         = rt_q;
  assign bus.ex_rd         = rd_q;
  assign bus.ex_data1      = data1_q;
  assign bus.ex_data2      = data2_q;
  assign bus.ex_imm        = imm_q;
  assign bus.ex_pc2        = pc2_q;
  assign bus.ex_alu_op     = alu_op_q;
  assign bus.ex_reg_write  = ctrl_q.reg_write;
  assign bus.ex_mem_read   = ctrl_q.mem_read;
  assign bus.ex_mem_write  = ctrl_q.mem_write;
  assign bus.ex_mem_to_reg = ctrl_q.mem_to_reg;
  assign bus.ex_alu_src    = ctrl_q.alu_src;
  assign bus.ex_halt       = ctrl_q.halt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: load-use stalls, store exemption, R0,
// memory freeze, flush, counter saturation and asynchronous reset.
module tb_id_ex_stage;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       mem_stall = 1'b0;
  logic       id_flush = 1'b0;
  logic       pc_hold, ifid_hold, pc_hold_s, ifid_hold_s;
  logic [15:0] cnt;
  logic [3:0]  cnt_s;

  int n_tests = 0;
  int n_fail  = 0;

  id_ex_stage_if bus ();
  id_ex_stage_if bus_s ();

  // Clock
  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .mem_stall(mem_stall), .id_flush(id_flush),
    .bus(bus), .pc_hold(pc_hold), .ifid_hold(ifid_hold), .lu_stall_cnt(cnt)
  );

  // Narrow-counter copy sees identical stimulus.
  id_ex_stage #(.CW(4)) dut_s (
    .clk(clk), .rst_n(rst_n), .mem_stall(mem_stall), .id_flush(id_flush),
    .bus(bus_s), .pc_hold(pc_hold_s), .ifid_hold(ifid_hold_s), .lu_stall_cnt(cnt_s)
  );

  assign bus_s.id_rs         = bus.id_rs;
  assign bus_s.id_rt         = bus.id_rt;
  assign bus_s.id_rd         = bus.id_rd;
  assign bus_s.id_uses_rs    = bus.id_uses_rs;
  assign bus_s.id_uses_rt    = bus.id_uses_rt;
  assign bus_s.id_is_store   = bus.id_is_store;
  assign bus_s.id_data1      = bus.id_data1;
  assign bus_s.id_data2      = bus.id_data2;
  assign bus_s.id_imm        = bus.id_imm;
  assign bus_s.id_pc2        = bus.id_pc2;
  assign bus_s.id_reg_write  = bus.id_reg_write;
  assign bus_s.id_mem_read   = bus.id_mem_read;
  assign bus_s.id_mem_write  = bus.id_mem_write;
  assign bus_s.id_mem_to_reg = bus.id_mem_to_reg;
  assign bus_s.id_alu_src    = bus.id_alu_src;
  assign bus_s.id_halt       = bus.id_halt;
  assign bus_s.id_alu_op     = bus.id_alu_op;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_id(input logic [3:0] rs, rt, rd, input logic urs, urt, st,
                        input logic mr, mw, rw, m2r, asrc, hlt, input logic [3:0] alu,
                        input logic [15:0] d1, d2, imm, pc2);
    bus.id_rs = rs; bus.id_rt = rt; bus.id_rd = rd;
    bus.id_uses_rs = urs; bus.id_uses_rt = urt; bus.id_is_store = st;
    bus.id_mem_read = mr; bus.id_mem_write = mw; bus.id_reg_write = rw;
    bus.id_mem_to_reg = m2r; bus.id_alu_src = asrc; bus.id_halt = hlt;
    bus.id_alu_op = alu;
    bus.id_data1 = d1; bus.id_data2 = d2; bus.id_imm = imm; bus.id_pc2 = pc2;
  endtask

  // Driver tasks for the instruction shapes used below.
  task automatic drive_nop();
    set_id(4'd0, 4'd0, 4'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 16'h0, 16'h0, 16'h0, 16'h0);
  endtask
  task automatic drive_lw(input logic [3:0] rd, base);
    set_id(base, 4'd0, rd, 1, 0, 0, 1, 0, 1, 1, 1, 0, 4'h0, 16'h1000, 16'h0, 16'h0004, 16'h0100);
  endtask
  task automatic drive_add(input logic [3:0] rd, rs, rt);
    set_id(rs, rt, rd, 1, 1, 0, 0, 0, 1, 0, 0, 0, 4'h0, 16'hA5A5, 16'h0F0F, 16'h0, 16'h0102);
  endtask
  task automatic drive_sw(input logic [3:0] base, src);
    set_id(base, src, 4'd0, 1, 1, 1, 0, 1, 0, 0, 1, 0, 4'h0, 16'h2000, 16'h1234, 16'h0002, 16'h0104);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive_nop();
    // Reset
    #12;
    check("rst_ex_rd", bus.ex_rd, 0);
    check("rst_ex_reg_write", bus.ex_reg_write, 0);
    check("rst_cnt", cnt, 0);
    check("rst_pc_hold", pc_hold, 0);
    rst_n = 1'b1;
    step();

    // Plain pass-through with halt and alu_op
    set_id(4'd1, 4'd2, 4'd9, 1, 1, 0, 0, 0, 1, 0, 1, 1, 4'h7, 16'h1111, 16'h2222, 16'hFFF8, 16'h0042);
    #1;
    check("pass_hold", pc_hold, 0);
    step();
    check("pass_rd", bus.ex_rd, 9);
    check("pass_halt", bus.ex_halt, 1);
    check("pass_alu_op", bus.ex_alu_op, 7);
    check("pass_imm", bus.ex_imm, 16'hFFF8);
    check("pass_pc2", bus.ex_pc2, 16'h0042);
    check("pass_alu_src", bus.ex_alu_src, 1);

    // LW R3 then ADD R4,R3,R5: one bubble
    drive_lw(4'd3, 4'd6);
    step();
    check("lw_ex_mem_read", bus.ex_mem_read, 1);
    drive_add(4'd4, 4'd3, 4'd5);
    #1;
    check("lu_pc_hold", pc_hold, 1);
    check("lu_ifid_hold", ifid_hold, 1);
    step();
    check("lu_bub_reg_write", bus.ex_reg_write, 0);
    check("lu_bub_rd", bus.ex_rd, 0);
    check("lu_bub_data1", bus.ex_data1, 0);
    check("lu_cnt", cnt, 1);
    check("lu_hold_released", pc_hold, 0);
    step();
    check("lu_dep_rs", bus.ex_rs, 3);
    check("lu_dep_rd", bus.ex_rd, 4);
    check("lu_dep_data1", bus.ex_data1, 16'hA5A5);
    check("lu_dep_data2", bus.ex_data2, 16'h0F0F);
    check("lu_cnt_after", cnt, 1);

    // LW R3 then SW R3 -> [R6]: no stall
    drive_lw(4'd3, 4'd6);
    step();
    drive_sw(4'd6, 4'd3);
    #1;
    check("sw_rt_hold", pc_hold, 0);
    step();
    check("sw_rt_mem_write", bus.ex_mem_write, 1);
    check("sw_rt_rt", bus.ex_rt, 3);
    check("sw_rt_cnt", cnt, 1);

    // LW R3 then SW R7 -> [R3]: base dependence stalls
    drive_lw(4'd3, 4'd6);
    step();
    drive_sw(4'd3, 4'd7);
    #1;
    check("sw_rs_hold", pc_hold, 1);
    step();
    check("sw_rs_bub_mem_write", bus.ex_mem_write, 0);
    check("sw_rs_cnt", cnt, 2);
    step();
    check("sw_rs_mem_write", bus.ex_mem_write, 1);
    check("sw_rs_rs", bus.ex_rs, 3);

    // LW R0 then consumer of R0: no stall
    drive_lw(4'd0, 4'd6);
    step();
    drive_add(4'd4, 4'd0, 4'd0);
    #1;
    check("r0_hold", pc_hold, 0);
    step();
    check("r0_rd", bus.ex_rd, 4);
    check("r0_reg_write", bus.ex_reg_write, 1);
    check("r0_cnt", cnt, 2);

    // Hazard under a 3-cycle memory freeze
    drive_lw(4'd3, 4'd6);
    step();
    drive_add(4'd4, 4'd3, 4'd5);
    mem_stall = 1'b1;
    #1;
    check("ms_hold", pc_hold, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("ms_frozen_mem_read", bus.ex_mem_read, 1);
      check("ms_frozen_rd", bus.ex_rd, 3);
      check("ms_frozen_cnt", cnt, 2);
    end
    mem_stall = 1'b0;
    #1;
    check("ms_release_hold", pc_hold, 1);
    step();
    check("ms_bub_rd", bus.ex_rd, 0);
    check("ms_bub_mem_read", bus.ex_mem_read, 0);
    check("ms_cnt", cnt, 3);
    step();
    check("ms_dep_rd", bus.ex_rd, 4);

    // Flush with concurrent hazard
    drive_lw(4'd3, 4'd6);
    step();
    drive_add(4'd4, 4'd3, 4'd5);
    id_flush = 1'b1;
    #1;
    check("fl_pc_hold", pc_hold, 0);
    check("fl_ifid_hold", ifid_hold, 0);
    step();
    id_flush = 1'b0;
    check("fl_rd", bus.ex_rd, 0);
    check("fl_reg_write", bus.ex_reg_write, 0);
    check("fl_data1", bus.ex_data1, 0);
    check("fl_cnt", cnt, 3);

    // LW R3,[R3] held in ID: a stall every second edge, 20 stalls in 40 edges
    drive_lw(4'd3, 4'd3);
    for (int i = 0; i < 40; i++) step();
    check("sat_cnt_wide", cnt, 23);
    check("sat_cnt_narrow", cnt_s, 4'hF);
    step();
    check("sat_stall_active", pc_hold, 1);

    // Asynchronous reset in the middle of a stall
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_ex_mem_read", bus.ex_mem_read, 0);
    check("ar_ex_rd", bus.ex_rd, 0);
    check("ar_ex_rs", bus.ex_rs, 0);
    check("ar_cnt", cnt, 0);
    check("ar_cnt_narrow", cnt_s, 0);
    check("ar_pc_hold", pc_hold, 0);
    check("ar_ifid_hold", ifid_hold, 0);
    #10;
    rst_n = 1'b1;
    step();
    check("restart_rd", bus.ex_rd, 3);
    check("restart_cnt", cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

endmodule
